mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single 32-bit word memory port.
//
// Each access takes one IDLE->ACCESS->RESP->IDLE trip. The winner's request is latched on
// leaving IDLE. The memory port is driven only during ACCESS. The requester gets a one-cycle
// ack in RESP. For reads, the registered read data is already valid in that ack cycle.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   req0/1, we0/1            request and write-enable per requester
//   addr0/1, wdata0/1        word address and write data per requester
//   ack0/1                   one-cycle completion pulse per requester
//   rdata0/1                 read data per requester, held until that port's next read
//   mem_address              memory address, zero outside ACCESS
//   mem_write_data           memory write data, zero outside ACCESS
//   mem_write                memory write enable, zero outside ACCESS
//   mem_read_data            combinational read data from the memory
//   busy                     high whenever a transaction is in flight
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        winner;

    // On a tie, the port that did not win last time is granted.
    // A lone requester always wins.
    always_comb begin
        if (req0) begin
            winner = req1 ? ~last_grant_q : 1'b0;
        end else begin
            winner = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d      = StAccess;
                    grant_d      = winner;
                    last_grant_d = winner;
                    we_d         = winner ? we1 : we0;
                    addr_d       = winner ? addr1 : addr0;
                    wdata_d      = winner ? wdata1 : wdata0;
                end
            end
            StAccess: begin
                state_d = StResp;
                // Writes leave the requester's read-data register untouched.
                if (!we_q) begin
                    if (grant_q) begin
                        rdata1_d = mem_read_data;
                    end else begin
                        rdata0_d = mem_read_data;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Outputs decode straight from state_q.
    // Reset therefore clears them asynchronously, including a pending write or ack.
    always_comb begin
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        mem_write      = 1'b0;
        if (state_q == StAccess) begin
            mem_address    = addr_q;
            mem_write_data = wdata_q;
            mem_write      = we_q;
        end
    end

    assign ack0   = (state_q == StResp) && !grant_q;
    assign ack1   = (state_q == StResp) && grant_q;
    assign busy   = (state_q != StIdle);
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Expected acks and memory writes are queued by the stimulus and popped by an independent
// negedge monitor. Cycle-accurate directed checks sit alongside the stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, mem_write, busy;
    logic [31:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;

    logic [31:0] mem [0:31];

    typedef struct {
        logic        port;
        logic        is_read;
        logic [31:0] data;
    } ack_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    ack_exp_t ack_q[$];
    wr_exp_t  wr_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (req0),
        .req1           (req1),
        .we0            (we0),
        .we1            (we1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .ack0           (ack0),
        .ack1           (ack1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    assign mem_read_data = mem[mem_address[4:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: preset contents, then commit writes at mid-cycle of ACCESS.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[3]  = 32'hA5A5_A5A5;
        mem[5]  = 32'hDEAD_BEEF;
        mem[10] = 32'h1010_1010;
        mem[20] = 32'h2020_2020;
        forever begin
            @(negedge clk);
            if (mem_write) mem[mem_address[4:0]] = mem_write_data;
        end
    end

    // Monitor: scores every ack and every memory write against the queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ack0 && ack1) check("both_acks", {ack1, ack0}, 32'h1);
                if (ack0 || ack1) begin
                    if (ack_q.size() == 0) begin
                        check("unexpected_ack", {ack1, ack0}, 32'h0);
                    end else begin
                        ack_exp_t e;
                        e = ack_q.pop_front();
                        check("ack_port", {31'd0, ack1}, {31'd0, e.port});
                        if (e.is_read) check("ack_rdata", e.port ? rdata1 : rdata0, e.data);
                    end
                end
                if (mem_write) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", {31'd0, mem_write}, 32'h0);
                    end else begin
                        wr_exp_t w;
                        w = wr_q.pop_front();
                        check("wr_addr", mem_address, w.addr);
                        check("wr_data", mem_write_data, w.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, asserted from time 0.
        #2;
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_ack", {30'd0, ack1, ack0}, 32'h0);
        check("rst_mem_write", {31'd0, mem_write}, 32'h0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single read from port 0, word 5.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        ack_q.push_back('{port: 1'b0, is_read: 1'b1, data: 32'hDEAD_BEEF});
        tick();
        check("rd_busy", {31'd0, busy}, 32'h1);
        check("rd_mem_addr", mem_address, 32'd5);
        check("rd_mem_write", {31'd0, mem_write}, 32'h0);
        tick();
        check("rd_ack0", {31'd0, ack0}, 32'h1);
        check("rd_ack1", {31'd0, ack1}, 32'h0);
        check("rd_rdata0", rdata0, 32'hDEAD_BEEF);
        req0 = 1'b0;
        tick();
        check("rd_idle", {31'd0, busy}, 32'h0);
        check("rd_addr_idle", mem_address, 32'h0);

        // Write from port 1, then read the written word back through port 0.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd7; wdata1 = 32'h1234_5678;
        wr_q.push_back('{addr: 32'd7, data: 32'h1234_5678});
        ack_q.push_back('{port: 1'b1, is_read: 1'b0, data: 32'h0});
        tick();
        check("wr_mem_write", {31'd0, mem_write}, 32'h1);
        check("wr_mem_addr", mem_address, 32'd7);
        tick();
        check("wr_write_one_cycle", {31'd0, mem_write}, 32'h0);
        check("wr_ack1", {31'd0, ack1}, 32'h1);
        check("wr_rdata1_kept", rdata1, 32'h0);
        req1 = 1'b0; we1 = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
        ack_q.push_back('{port: 1'b0, is_read: 1'b1, data: 32'h1234_5678});
        tick();
        tick();
        check("rb_ack0", {31'd0, ack0}, 32'h1);
        check("rb_rdata0", rdata0, 32'h1234_5678);
        req0 = 1'b0;
        tick();

        // Tie after reset: grants alternate 0, 1, 0, 1, one access every 3 cycles.
        reset = 1'b1;
        #1;
        check("tie_rst_rdata0", rdata0, 32'h0);
        tick();
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd20;
        for (int i = 0; i < 4; i++) begin
            ack_q.push_back('{port: i[0], is_read: 1'b1,
                              data: i[0] ? 32'h2020_2020 : 32'h1010_1010});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tie_access_addr", mem_address, i[0] ? 32'd20 : 32'd10);
            tick();
            check("tie_ack0", {31'd0, ack0}, {31'd0, ~i[0]});
            check("tie_ack1", {31'd0, ack1}, {31'd0, i[0]});
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
            if (i < 3) check("tie_idle_gap", {31'd0, busy}, 32'h0);
        end
        check("tie_done_idle", {31'd0, busy}, 32'h0);

        // One-cycle request pulse still completes.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        ack_q.push_back('{port: 1'b0, is_read: 1'b1, data: 32'hDEAD_BEEF});
        tick();
        req0 = 1'b0;
        tick();
        check("drop_ack0", {31'd0, ack0}, 32'h1);
        tick();
        check("drop_busy", {31'd0, busy}, 32'h0);
        tick();
        check("drop_still_idle", {31'd0, busy}, 32'h0);
        check("drop_no_ack", {30'd0, ack1, ack0}, 32'h0);

        // Reset in the middle of a write to word 3.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd3; wdata1 = 32'hDEAD_0003;
        tick();
        check("abort_write_on", {31'd0, mem_write}, 32'h1);
        check("abort_addr", mem_address, 32'd3);
        reset = 1'b1;
        #1;
        check("abort_write_off", {31'd0, mem_write}, 32'h0);
        check("abort_addr_zero", mem_address, 32'h0);
        check("abort_busy", {31'd0, busy}, 32'h0);
        req1 = 1'b0; we1 = 1'b0;
        tick();
        check("abort_no_ack", {30'd0, ack1, ack0}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("abort_mem3", mem[3], 32'hA5A5_A5A5);
        check("abort_idle", {31'd0, busy}, 32'h0);

        // Every expectation must have been consumed by the monitor.
        check("ack_queue_empty", ack_q.size(), 32'd0);
        check("wr_queue_empty", wr_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
